// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the 5-stage RV64 pipeline: widths, ALU encoding,
// forwarding select codes and the EX control bundle.
package riscv_pipe_pkg;

   localparam int XLEN = 64;
   localparam int REGW = 5;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_OR  = 2'd3
   } alu_ctrl_e;

   localparam logic [1:0] FW_REG   = 2'd0;
   localparam logic [1:0] FW_EXMEM = 2'd1;
   localparam logic [1:0] FW_MEMWB = 2'd2;
   localparam logic [1:0] FW_WBX   = 2'd3;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic [1:0] alu_ctrl;
   } ctrl_t;

   // x0 is never a real producer, so a write to it can not be forwarded
   function automatic logic rd_match(input logic            we,
                                     input logic [REGW-1:0] rd,
                                     input logic [REGW-1:0] rs);
      return we && (rd != {REGW{1'b0}}) && (rd == rs);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-to-EX bus: decoded fields from ID and the registered EX-stage copies.
interface id_ex_stage_if;

   logic                                 id_valid;
   logic [riscv_pipe_pkg::XLEN-1:0]      id_data1;
   logic [riscv_pipe_pkg::XLEN-1:0]      id_data2;
   logic [riscv_pipe_pkg::XLEN-1:0]      id_imm;
   logic [riscv_pipe_pkg::REGW-1:0]      id_rs1;
   logic [riscv_pipe_pkg::REGW-1:0]      id_rs2;
   logic [riscv_pipe_pkg::REGW-1:0]      id_rd;
   logic                                 id_use_rs1;
   logic                                 id_use_rs2;
   logic                                 id_alu_src;
   logic [1:0]                           id_alu_ctrl;
   logic                                 id_reg_write;
   logic                                 id_mem_read;
   logic                                 id_mem_write;
   logic                                 id_mem_to_reg;

   logic                                 ex_valid;
   logic [riscv_pipe_pkg::XLEN-1:0]      ex_data1;
   logic [riscv_pipe_pkg::XLEN-1:0]      ex_data2;
   logic [riscv_pipe_pkg::XLEN-1:0]      ex_imm;
   logic [riscv_pipe_pkg::REGW-1:0]      ex_rd;
   logic                                 ex_alu_src;
   logic [1:0]                           ex_alu_ctrl;
   logic                                 ex_reg_write;
   logic                                 ex_mem_read;
   logic                                 ex_mem_write;
   logic                                 ex_mem_to_reg;

   modport master (
      output id_valid, id_data1, id_data2, id_imm, id_rs1, id_rs2, id_rd,
             id_use_rs1, id_use_rs2, id_alu_src, id_alu_ctrl,
             id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
      input  ex_valid, ex_data1, ex_data2, ex_imm, ex_rd, ex_alu_src,
             ex_alu_ctrl, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
   );

   modport slave (
      input  id_valid, id_data1, id_data2, id_imm, id_rs1, id_rs2, id_rd,
             id_use_rs1, id_use_rs2, id_alu_src, id_alu_ctrl,
             id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
      output ex_valid, ex_data1, ex_data2, ex_imm, ex_rd, ex_alu_src,
             ex_alu_ctrl, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
   );

endinterface

// File: rtl/fwd_unit.sv
// Forwarding select for one EX operand; the nearest producing stage wins.
module fwd_unit
   import riscv_pipe_pkg::*;
(
   input  logic [REGW-1:0] rs_i,
   input  logic [REGW-1:0] exmem_rd_i,
   input  logic [REGW-1:0] memwb_rd_i,
   input  logic [REGW-1:0] wbx_rd_i,
   input  logic            exmem_we_i,
   input  logic            memwb_we_i,
   input  logic            wbx_we_i,
   output logic [1:0]      sel_o
);

   // priority search from EX/MEM outward
   always_comb begin
      sel_o = FW_REG;
      if (rd_match(exmem_we_i, exmem_rd_i, rs_i)) begin
         sel_o = FW_EXMEM;
      end else if (rd_match(memwb_we_i, memwb_rd_i, rs_i)) begin
         sel_o = FW_MEMWB;
      end else if (rd_match(wbx_we_i, wbx_rd_i, rs_i)) begin
         sel_o = FW_WBX;
      end else begin
         sel_o = FW_REG;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and forwarding
// select generation for the execute stage.
module id_ex_stage
   import riscv_pipe_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   id_ex_stage_if.slave    bus,
   input  logic            flush_i,
   input  logic            hold_i,
   input  logic [REGW-1:0] exmem_rd,
   input  logic [REGW-1:0] memwb_rd,
   input  logic [REGW-1:0] wbx_rd,
   input  logic            exmem_we,
   input  logic            memwb_we,
   input  logic            wbx_we,
   output logic [1:0]      sel_fw_a,
   output logic [1:0]      sel_fw_b,
   output logic            stall_o
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] data1_q, data1_d;
   logic [XLEN-1:0] data2_q, data2_d;
   logic [XLEN-1:0] imm_q,   imm_d;
   logic [REGW-1:0] rs1_q,   rs1_d;
   logic [REGW-1:0] rs2_q,   rs2_d;
   logic [REGW-1:0] rd_q,    rd_d;
   ctrl_t           ctrl_q,  ctrl_d;

   ctrl_t           id_ctrl_s;
   logic            luh_s;
   logic [1:0]      raw_fw_a_s;
   logic [1:0]      raw_fw_b_s;

   // decoded control from ID, qualified by id_valid so a non-instruction carries no side effects
   always_comb begin
      id_ctrl_s.reg_write  = bus.id_reg_write  & bus.id_valid;
      id_ctrl_s.mem_read   = bus.id_mem_read   & bus.id_valid;
      id_ctrl_s.mem_write  = bus.id_mem_write  & bus.id_valid;
      id_ctrl_s.mem_to_reg = bus.id_mem_to_reg & bus.id_valid;
      id_ctrl_s.alu_src    = bus.id_alu_src    & bus.id_valid;
      id_ctrl_s.alu_ctrl   = bus.id_alu_ctrl   & {2{bus.id_valid}};
   end

   // load in EX whose result ID needs now: data is not available until MEM/WB
   always_comb begin
      luh_s = 1'b0;
      if (valid_q && ctrl_q.mem_read && (rd_q != {REGW{1'b0}}) && bus.id_valid) begin
         luh_s = (bus.id_use_rs1 && (bus.id_rs1 == rd_q)) ||
                 (bus.id_use_rs2 && (bus.id_rs2 == rd_q));
      end else begin
         luh_s = 1'b0;
      end
   end

   assign stall_o = hold_i | luh_s;

   // next EX contents: hold, then bubble (flush or load-use), then capture
   always_comb begin
      valid_d = valid_q;
      data1_d = data1_q;
      data2_d = data2_q;
      imm_d   = imm_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      rd_d    = rd_q;
      ctrl_d  = ctrl_q;
      if (hold_i) begin
         valid_d = valid_q;
      end else if (flush_i || luh_s) begin
         valid_d = 1'b0;
         data1_d = {XLEN{1'b0}};
         data2_d = {XLEN{1'b0}};
         imm_d   = {XLEN{1'b0}};
         rs1_d   = {REGW{1'b0}};
         rs2_d   = {REGW{1'b0}};
         rd_d    = {REGW{1'b0}};
         ctrl_d  = '0;
      end else begin
         valid_d = bus.id_valid;
         data1_d = bus.id_data1;
         data2_d = bus.id_data2;
         imm_d   = bus.id_imm;
         rs1_d   = bus.id_rs1;
         rs2_d   = bus.id_rs2;
         rd_d    = bus.id_rd;
         ctrl_d  = id_ctrl_s;
      end
   end

   // EX-stage register bank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data1_q <= {XLEN{1'b0}};
         data2_q <= {XLEN{1'b0}};
         imm_q   <= {XLEN{1'b0}};
         rs1_q   <= {REGW{1'b0}};
         rs2_q   <= {REGW{1'b0}};
         rd_q    <= {REGW{1'b0}};
         ctrl_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data1_q <= data1_d;
         data2_q <= data2_d;
         imm_q   <= imm_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // operand B is forwarded even for immediate ops, since stores use rs2 data
   fwd_unit u_fwd_a (
      .rs_i       (rs1_q),
      .exmem_rd_i (exmem_rd),
      .memwb_rd_i (memwb_rd),
      .wbx_rd_i   (wbx_rd),
      .exmem_we_i (exmem_we),
      .memwb_we_i (memwb_we),
      .wbx_we_i   (wbx_we),
      .sel_o      (raw_fw_a_s)
   );

   fwd_unit u_fwd_b (
      .rs_i       (rs2_q),
      .exmem_rd_i (exmem_rd),
      .memwb_rd_i (memwb_rd),
      .wbx_rd_i   (wbx_rd),
      .exmem_we_i (exmem_we),
      .memwb_we_i (memwb_we),
      .wbx_we_i   (wbx_we),
      .sel_o      (raw_fw_b_s)
   );

   // a bubble in EX never selects a bypass path
   always_comb begin
      sel_fw_a = FW_REG;
      sel_fw_b = FW_REG;
      if (valid_q) begin
         sel_fw_a = raw_fw_a_s;
         sel_fw_b = raw_fw_b_s;
      end else begin
         sel_fw_a = FW_REG;
         sel_fw_b = FW_REG;
      end
   end

   assign bus.ex_valid      = valid_q;
   assign bus.ex_data1      = data1_q;
   assign bus.ex_data2      = data2_q;
   assign bus.ex_imm        = imm_q;
   assign bus.ex_rd         = rd_q;
   assign bus.ex_alu_src    = ctrl_q.alu_src;
   assign bus.ex_alu_ctrl   = ctrl_q.alu_ctrl;
   assign bus.ex_reg_write  = ctrl_q.reg_write;
   assign bus.ex_mem_read   = ctrl_q.mem_read;
   assign bus.ex_mem_write  = ctrl_q.mem_write;
   assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, forwarding, load-use, flush/hold.
module tb_id_ex_stage;

   logic       clk;
   logic       rst_n;
   logic       flush_i;
   logic       hold_i;
   logic [4:0] exmem_rd, memwb_rd, wbx_rd;
   logic       exmem_we, memwb_we, wbx_we;
   logic [1:0] sel_fw_a, sel_fw_b;
   logic       stall_o;
   int         tests;
   int         fails;

   id_ex_stage_if bus();

   id_ex_stage dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .flush_i  (flush_i),
      .hold_i   (hold_i),
      .exmem_rd (exmem_rd),
      .memwb_rd (memwb_rd),
      .wbx_rd   (wbx_rd),
      .exmem_we (exmem_we),
      .memwb_we (memwb_we),
      .wbx_we   (wbx_we),
      .sel_fw_a (sel_fw_a),
      .sel_fw_b (sel_fw_b),
      .stall_o  (stall_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_side();
      flush_i = 1'b0; hold_i = 1'b0;
      exmem_rd = 5'd0; memwb_rd = 5'd0; wbx_rd = 5'd0;
      exmem_we = 1'b0; memwb_we = 1'b0; wbx_we = 1'b0;
   endtask

   task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic u1, input logic u2,
                           input logic mr, input logic rw, input logic [63:0] d1);
      bus.id_valid = v; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
      bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
      bus.id_mem_read = mr; bus.id_reg_write = rw; bus.id_mem_to_reg = mr;
      bus.id_mem_write = 1'b0; bus.id_alu_src = 1'b0; bus.id_alu_ctrl = 2'd0;
      bus.id_data1 = d1; bus.id_data2 = 64'h0; bus.id_imm = 64'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_side();
      drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
      repeat (2) tick();
      tests++; if (bus.ex_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0h exp 0", bus.ex_valid); end
      tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL rst_stall: got %0h exp 0", stall_o); end
      rst_n = 1'b1;
      drive_id(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 64'h1234);
      tick();
      exmem_rd = 5'd5; exmem_we = 1'b1;
      #1;
      tests++; if (sel_fw_a !== 2'd1 || bus.ex_valid !== 1'b1) begin fails++; $display("FAIL pre_rst: got sel %0d valid %0h exp 1 1", sel_fw_a, bus.ex_valid); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_data1 !== 64'h0 || bus.ex_rd !== 5'd0)
         begin fails++; $display("FAIL async_rst_regs: got v %0h rw %0h d1 %0h rd %0d exp all 0", bus.ex_valid, bus.ex_reg_write, bus.ex_data1, bus.ex_rd); end
      tests++; if (sel_fw_a !== 2'd0 || sel_fw_b !== 2'd0 || stall_o !== 1'b0)
         begin fails++; $display("FAIL async_rst_out: got a %0d b %0d st %0h exp 0 0 0", sel_fw_a, sel_fw_b, stall_o); end
      @(negedge clk);
      rst_n = 1'b1;
      clear_side();
   endtask

   task automatic test_capture();
      drive_id(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001);
      bus.id_data2 = 64'h0000_0000_CAFE_0002; bus.id_imm = 64'hFFFF_FFFF_FFFF_FFF0;
      bus.id_alu_src = 1'b1; bus.id_alu_ctrl = 2'd2; bus.id_mem_write = 1'b1;
      tick();
      tests++; if (bus.ex_valid !== 1'b1 || bus.ex_data1 !== 64'hDEAD_BEEF_0000_0001 || bus.ex_data2 !== 64'h0000_0000_CAFE_0002)
         begin fails++; $display("FAIL cap_data: got v %0h d1 %0h d2 %0h", bus.ex_valid, bus.ex_data1, bus.ex_data2); end
      tests++; if (bus.ex_imm !== 64'hFFFF_FFFF_FFFF_FFF0 || bus.ex_rd !== 5'd12 || bus.ex_alu_ctrl !== 2'd2 || bus.ex_alu_src !== 1'b1)
         begin fails++; $display("FAIL cap_fields: got imm %0h rd %0d ctl %0d src %0h", bus.ex_imm, bus.ex_rd, bus.ex_alu_ctrl, bus.ex_alu_src); end
      tests++; if (bus.ex_reg_write !== 1'b1 || bus.ex_mem_write !== 1'b1 || bus.ex_mem_read !== 1'b0)
         begin fails++; $display("FAIL cap_ctrl: got rw %0h mw %0h mr %0h exp 1 1 0", bus.ex_reg_write, bus.ex_mem_write, bus.ex_mem_read); end
      bus.id_valid = 1'b0;
      tick();
      tests++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_write !== 1'b0 || bus.ex_alu_ctrl !== 2'd0)
         begin fails++; $display("FAIL cap_invalid: got v %0h rw %0h mw %0h ctl %0d exp 0", bus.ex_valid, bus.ex_reg_write, bus.ex_mem_write, bus.ex_alu_ctrl); end
   endtask

   task automatic test_forwarding();
      drive_id(1'b1, 5'd5, 5'd9, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0);
      tick();
      exmem_rd = 5'd5; exmem_we = 1'b1; #1;
      tests++; if (sel_fw_a !== 2'd1 || sel_fw_b !== 2'd0) begin fails++; $display("FAIL fw_exmem: got a %0d b %0d exp 1 0", sel_fw_a, sel_fw_b); end
      exmem_we = 1'b0; memwb_rd = 5'd5; memwb_we = 1'b1; #1;
      tests++; if (sel_fw_a !== 2'd2) begin fails++; $display("FAIL fw_memwb: got %0d exp 2", sel_fw_a); end
      memwb_we = 1'b0; wbx_rd = 5'd5; wbx_we = 1'b1; #1;
      tests++; if (sel_fw_a !== 2'd3) begin fails++; $display("FAIL fw_wbx: got %0d exp 3", sel_fw_a); end
      wbx_rd = 5'd9; #1;
      tests++; if (sel_fw_a !== 2'd0 || sel_fw_b !== 2'd3) begin fails++; $display("FAIL fw_b_wbx: got a %0d b %0d exp 0 3", sel_fw_a, sel_fw_b); end
      clear_side();
      drive_id(1'b1, 5'd1, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0);
      bus.id_alu_src = 1'b1;
      tick();
      exmem_rd = 5'd7; exmem_we = 1'b1; memwb_rd = 5'd7; memwb_we = 1'b1; #1;
      tests++; if (sel_fw_b !== 2'd1) begin fails++; $display("FAIL fw_prio: got %0d exp 1", sel_fw_b); end
      clear_side();
      drive_id(1'b1, 5'd1, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0);
      tick();
      exmem_rd = 5'd0; exmem_we = 1'b1; memwb_rd = 5'd0; memwb_we = 1'b1; #1;
      tests++; if (sel_fw_b !== 2'd0) begin fails++; $display("FAIL fw_x0: got %0d exp 0", sel_fw_b); end
      clear_side();
      drive_id(1'b0, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0);
      tick();
      exmem_rd = 5'd5; exmem_we = 1'b1; #1;
      tests++; if (sel_fw_a !== 2'd0 || sel_fw_b !== 2'd0) begin fails++; $display("FAIL fw_bubble: got a %0d b %0d exp 0 0", sel_fw_a, sel_fw_b); end
      clear_side();
   endtask

   task automatic test_load_use();
      drive_id(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0);
      tick();
      drive_id(1'b1, 5'd3, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0);
      #1;
      tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL luh_stall: got %0h exp 1", stall_o); end
      tick();
      tests++; if (bus.ex_valid !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL luh_bubble: got v %0h st %0h exp 0 0", bus.ex_valid, stall_o); end
      exmem_rd = 5'd3; exmem_we = 1'b1;
      tick();
      exmem_we = 1'b0; memwb_rd = 5'd3; memwb_we = 1'b1; #1;
      tests++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6 || sel_fw_a !== 2'd2)
         begin fails++; $display("FAIL luh_resolve: got v %0h rd %0d sel %0d exp 1 6 2", bus.ex_valid, bus.ex_rd, sel_fw_a); end
      clear_side();
      drive_id(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0);
      tick();
      drive_id(1'b1, 5'd3, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
      #1;
      tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL luh_nouse: got %0h exp 0", stall_o); end
      tick();
      tests++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6) begin fails++; $display("FAIL luh_nouse_cap: got v %0h rd %0d exp 1 6", bus.ex_valid, bus.ex_rd); end
   endtask

   task automatic test_flush_hold();
      drive_id(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 64'h1);
      flush_i = 1'b1;
      tick();
      tests++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_rd !== 5'd0)
         begin fails++; $display("FAIL flush: got v %0h rw %0h rd %0d exp 0 0 0", bus.ex_valid, bus.ex_reg_write, bus.ex_rd); end
      flush_i = 1'b0;
      drive_id(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 64'hAAAA);
      tick();
      drive_id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 64'h5555);
      flush_i = 1'b1; hold_i = 1'b1; #1;
      tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL hold_stall: got %0h exp 1", stall_o); end
      tick();
      tests++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd4 || bus.ex_data1 !== 64'hAAAA || bus.ex_reg_write !== 1'b1)
         begin fails++; $display("FAIL hold_keep: got v %0h rd %0d d1 %0h rw %0h exp 1 4 aaaa 1", bus.ex_valid, bus.ex_rd, bus.ex_data1, bus.ex_reg_write); end
      flush_i = 1'b0; hold_i = 1'b0;
      tick();
      tests++; if (bus.ex_rd !== 5'd8 || bus.ex_data1 !== 64'h5555) begin fails++; $display("FAIL hold_release: got rd %0d d1 %0h exp 8 5555", bus.ex_rd, bus.ex_data1); end
      drive_id(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0);
      tick();
      drive_id(1'b1, 5'd0, 5'd3, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0);
      flush_i = 1'b1; #1;
      tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL flush_luh_stall: got %0h exp 1", stall_o); end
      tick();
      flush_i = 1'b0; #1;
      tests++; if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0 || stall_o !== 1'b0)
         begin fails++; $display("FAIL flush_luh_after: got v %0h mr %0h st %0h exp 0 0 0", bus.ex_valid, bus.ex_mem_read, stall_o); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_capture();
      test_forwarding();
      test_load_use();
      test_flush_hold();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
